// File: rtl/serial_adder_pkg.sv
// ============================================================================
// serial_adder_pkg : shared state encoding and sizing helpers for serial_adder
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Step counter needs at least one bit even when a single step suffices.
    function automatic int step_cnt_w(input int nstep);
        return (nstep > 1) ? $clog2(nstep) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_slice.sv
// ============================================================================
// adder_slice : DIGIT-bit combinational ripple-carry slice
// Revision: 1.0
// ============================================================================
`default_nettype none

module adder_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder : multi-cycle add/subtract, DIGIT bits per clock, valid/ready
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            NSTEP = WIDTH / DIGIT;
    localparam int            CW    = step_cnt_w(NSTEP);
    localparam logic [CW-1:0] LAST  = CW'(NSTEP - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0]       slice_s;
    logic                   slice_co;
    logic                   slice_cmsb;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [WIDTH-1:0]       res_next;

    adder_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .x     (a_q[DIGIT-1:0]),
        .y     (b_q[DIGIT-1:0]),
        .ci    (carry_q),
        .s     (slice_s),
        .co    (slice_co),
        .c_msb (slice_cmsb)
    );

    // New digits enter at the MSB end so the word is aligned after NSTEP shifts.
    assign res_cat  = {slice_s, res_q};
    assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_next;
                carry_d = slice_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    sum_d   = res_next;
                    cout_d  = slice_co;
                    ovf_d   = slice_co ^ slice_cmsb;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder : directed self-checking bench, WIDTH=8 with DIGIT=2 and 8
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [7:0] a, b, sum;

    logic       d8_in_valid, d8_in_ready, d8_cin, d8_sub;
    logic       d8_out_valid, d8_out_ready, d8_cout, d8_ovf;
    logic [7:0] d8_a, d8_b, d8_sum;

    int n_vec;
    int n_err;

    serial_adder #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (d8_in_valid),
        .in_ready  (d8_in_ready),
        .a         (d8_a),
        .b         (d8_b),
        .cin       (d8_cin),
        .sub       (d8_sub),
        .out_valid (d8_out_valid),
        .out_ready (d8_out_ready),
        .sum       (d8_sum),
        .cout      (d8_cout),
        .ovf       (d8_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents operands and returns #1 after the accept edge.
    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb,
                            input logic tc, input logic ts);
        @(negedge clk);
        a        = ta;
        b        = tb;
        cin      = tc;
        sub      = ts;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("accept_in_ready", in_ready, 1'b0);
    endtask

    // Called #1 after the accept edge; result must appear after edge T+4.
    task automatic wait_result(input string tag, input logic [7:0] es,
                               input logic ec, input logic eo);
        repeat (3) @(posedge clk);
        #1 check({tag, "_early_valid"}, out_valid, 1'b0);
        @(posedge clk);
        #1 check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_cout"}, cout, ec);
        check({tag, "_ovf"}, ovf, eo);
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_rel_valid"}, out_valid, 1'b0);
        check({tag, "_rel_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        a            = '0;
        b            = '0;
        cin          = 1'b0;
        sub          = 1'b0;
        d8_in_valid  = 1'b0;
        d8_out_ready = 1'b0;
        d8_a         = '0;
        d8_b         = '0;
        d8_cin       = 1'b0;
        d8_sub       = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;

        start_op(8'h5A, 8'h33, 1'b1, 1'b0);
        wait_result("add_cin", 8'h8E, 1'b0, 1'b1);
        release_result("add_cin");
        check("idle_retain_sum", sum, 8'h8E);

        start_op(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_result("wrap", 8'h00, 1'b1, 1'b0);
        release_result("wrap");

        start_op(8'h10, 8'h20, 1'b1, 1'b1);
        wait_result("borrow", 8'hF0, 1'b0, 1'b0);
        release_result("borrow");

        start_op(8'h80, 8'h01, 1'b0, 1'b1);
        wait_result("sub_ovf", 8'h7F, 1'b1, 1'b1);
        release_result("sub_ovf");

        // Backpressure: new operands offered while DONE is held must be refused.
        start_op(8'h12, 8'h34, 1'b0, 1'b0);
        wait_result("bp", 8'h46, 1'b0, 1'b0);
        @(negedge clk);
        a        = 8'h01;
        b        = 8'h01;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_sum", sum, 8'h46);
            check("bp_in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp_rel_valid", out_valid, 1'b0);
        check("bp_rel_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp_next_accept", in_ready, 1'b0);
        wait_result("bp_next", 8'h02, 1'b0, 1'b0);
        release_result("bp_next");

        // Asynchronous reset two cycles into RUN.
        start_op(8'h77, 8'h11, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_sum", sum, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(8'h01, 8'h01, 1'b0, 1'b0);
        wait_result("post_rst", 8'h02, 1'b0, 1'b0);
        release_result("post_rst");

        // Single-step configuration.
        @(negedge clk);
        d8_a        = 8'h5A;
        d8_b        = 8'h33;
        d8_cin      = 1'b1;
        d8_sub      = 1'b0;
        d8_in_valid = 1'b1;
        @(posedge clk);
        #1 d8_in_valid = 1'b0;
        check("d8_accept_ready", d8_in_ready, 1'b0);
        check("d8_early_valid", d8_out_valid, 1'b0);
        @(posedge clk);
        #1;
        check("d8_valid", d8_out_valid, 1'b1);
        check("d8_sum", d8_sum, 8'h8E);
        check("d8_cout", d8_cout, 1'b0);
        check("d8_ovf", d8_ovf, 1'b1);
        @(negedge clk);
        d8_out_ready = 1'b1;
        @(posedge clk);
        #1 d8_out_ready = 1'b0;
        check("d8_rel_valid", d8_out_valid, 1'b0);
        check("d8_rel_ready", d8_in_ready, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
